ysyx_22040931_lsu: RTL
======================

# ysyx_22040931_lsu

Load/store unit placed directly downstream of the execute-stage ALU: takes the effective address the ALU produces (rs1 + imm), performs one RV64 load or store against the data-memory port with valid/ready handshakes, and returns the aligned, sign/zero-extended load result to writeback. It holds one transaction at a time. While it is busy, `req_ready` stays low, and that low `req_ready` is the signal that stalls the core.

## Interface
- `DATA_W`, 64, datapath and memory word width in bits (only 64 supported)
- `ADDR_W`, 64, address width in bits
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `req_valid`  in  1  request from EX stage
- `req_ready`  out  1  LSU idle and able to accept
- `req_op`  in  4  operation: LB=0, LH=1, LW=2, LD=3, LBU=4, LHU=5, LWU=6, SB=8, SH=9, SW=10, SD=11; other codes are illegal
- `req_addr`  in  ADDR_W  effective address (ALU result)
- `req_wdata`  in  DATA_W  store data (rs2), right-justified
- `mem_req_valid`  out  1  memory request
- `mem_req_ready`  in  1  memory accepts request
- `mem_addr`  out  ADDR_W  `req_addr` with bits [2:0] cleared
- `mem_wen`  out  1  1 = store, 0 = load
- `mem_wdata`  out  DATA_W  store data shifted into lanes
- `mem_wmask`  out  8  byte enables
- `mem_rvalid`  in  1  load data valid
- `mem_rdata`  in  DATA_W  load data (full aligned doubleword)
- `resp_valid`  out  1  result available
- `resp_ready`  in  1  writeback consumes result
- `resp_rdata`  out  DATA_W  extended load value; 0 for stores
- `resp_err`  out  1  misaligned access (checker builds only)

## Operation
- Transaction states: IDLE, REQ, WAIT, RESP.
- `req_ready` = (state==IDLE).
- IDLE: on `req_valid & req_ready`, register op, address, wdata.
  - Illegal op: go to RESP with `resp_rdata`=0 and `resp_err`=0, and issue no memory access.
  - Otherwise go to REQ.
- REQ: `mem_req_valid`=1, with `mem_addr`/`mem_wen`/`mem_wdata`/`mem_wmask` stable, held until `mem_req_ready`.
  - On that handshake, a store goes to RESP and a load goes to WAIT.
- WAIT: on `mem_rvalid`, capture the extracted load value and go to RESP.
  - `mem_rvalid` is ignored in every other state.
- RESP: `resp_valid`=1 with data stable until `resp_ready`, then go to IDLE.
  - `req_ready` does not rise in the same cycle as the response handshake.
- Lane rules, with off = addr[2:0] and size mask B=0x01, H=0x03, W=0x0F, D=0xFF:
  - `mem_wmask` = (size mask << off), truncated to 8 bits.
  - `mem_wdata` = `req_wdata` << (8*off).
  - Load value = `mem_rdata` >> (8*off), then sign-extend (LB/LH/LW/LD) or zero-extend (LBU/LHU/LWU) from the access size.
- Reset:
  - All outputs are 0 and the state is IDLE.
  - Asserting `rst` mid-transaction abandons it the next cycle. No response is produced, and any late `mem_rvalid` is ignored.

## Timing
- Minimum load latency: accept at T, memory handshake at T+1, `mem_rvalid` at T+2, `resp_valid` at T+3.
- Minimum store latency: accept at T, memory handshake at T+1, `resp_valid` at T+2.
- Throughput is one transaction per ≥3 cycles for a store and ≥4 for a load.
- `mem_*` outputs and `resp_*` outputs are registered. `req_ready` is decoded from state only, with no combinational path from any input.
- `resp_rdata`/`resp_err` remain unchanged while `resp_valid & !resp_ready`.

## Configuration
- `YSYX_22040931_LSU_MISALIGN_CHK_EN` defined:
  - An H access with addr[0]≠0, a W access with addr[1:0]≠0, or a D access with addr[2:0]≠0 goes IDLE→RESP directly.
  - It raises `resp_err`=1 with `resp_rdata`=0 and issues no memory request.
- Undefined:
  - There is no check and `resp_err` is tied to 0.
  - Lane bits beyond the doubleword are truncated as per the lane rules. An SD at off=4 writes mask 0xF0, and an LD at off=4 returns the upper word zero-filled.

## Structure
- `defines.v` holds the op codes as `` `ysyx_22040931_LSU_* `` and the state encodings, next to the existing ALU op defines.
- Sub-module `ysyx_22040931_lsu_ext` is a combinational load shift/extend of `mem_rdata`, off and op down to 64 bits, and is reused by the verification model.

## Test plan
- LW at addr 0x80000004, `mem_rdata`=0x8000_0001_1234_5678 → `resp_rdata`=0xFFFF_FFFF_8000_0001, with `resp_valid` at T+3 under a zero-wait memory.
- LBU at addr 0x80000003, `mem_rdata`=0x0000_0000_F1E2_D3C4 → `resp_rdata`=0x0000_0000_0000_00F1. LB at the same address → 0xFFFF_FFFF_FFFF_FFF1.
- SH at 0x80000006, wdata 0xABCD → `mem_wmask`=0xC0, `mem_wdata`[63:48]=0xABCD, `mem_addr`=0x80000000, `resp_valid` at T+2. Holding `mem_req_ready` low for 3 cycles keeps the `mem_*` outputs stable and delays the response by 3 cycles.
- Backpressure: hold `resp_ready` low for 5 cycles → `resp_valid`/`resp_rdata` stable, `req_ready` low throughout, and a new `req_valid` is not accepted.
- Reset while in WAIT, with `mem_rvalid` pulsed 2 cycles later → no `resp_valid`, all outputs 0, `req_ready`=1 the cycle after `rst` deasserts.
- Checker build: LD at 0x80000004 → `resp_err`=1 at T+1, `mem_req_valid` never asserted. Non-checker build: same request → `mem_wmask`/lane behaviour per truncation, `resp_err`=0.

Source files
------------

// File: rtl/ysyx_22040931_lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : ysyx_22040931_lsu_pkg
//  Brief   : Op codes, FSM state encodings and lane helpers for the LSU.
//  Revision: 1.0 - initial release
// ============================================================================
package ysyx_22040931_lsu_pkg;

    localparam logic [3:0] c_op_lb  = 4'd0;
    localparam logic [3:0] c_op_lh  = 4'd1;
    localparam logic [3:0] c_op_lw  = 4'd2;
    localparam logic [3:0] c_op_ld  = 4'd3;
    localparam logic [3:0] c_op_lbu = 4'd4;
    localparam logic [3:0] c_op_lhu = 4'd5;
    localparam logic [3:0] c_op_lwu = 4'd6;
    localparam logic [3:0] c_op_sb  = 4'd8;
    localparam logic [3:0] c_op_sh  = 4'd9;
    localparam logic [3:0] c_op_sw  = 4'd10;
    localparam logic [3:0] c_op_sd  = 4'd11;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_req  = 2'd1;
    localparam logic [1:0] c_st_wait = 2'd2;
    localparam logic [1:0] c_st_resp = 2'd3;

    function automatic logic op_is_legal(input logic [3:0] op);
        return (op != 4'd7) && (op <= c_op_sd);
    endfunction

    function automatic logic op_is_store(input logic [3:0] op);
        return op[3];
    endfunction

    // op[1:0] encodes the access size for every legal op
    function automatic logic [7:0] size_mask(input logic [3:0] op);
        case (op[1:0])
            2'd0:    return 8'h01;
            2'd1:    return 8'h03;
            2'd2:    return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [3:0] op, input logic [2:0] off);
        case (op[1:0])
            2'd1:    return off[0];
            2'd2:    return |off[1:0];
            2'd3:    return |off;
            default: return 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_22040931_lsu_if.sv
`default_nettype none
// ============================================================================
//  Module  : ysyx_22040931_lsu_if
//  Brief   : Request, data-memory and response bundle around the LSU.
//  Revision: 1.0 - initial release
// ============================================================================
interface ysyx_22040931_lsu_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 64
);
    logic              req_valid;
    logic              req_ready;
    logic [3:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wen;
    logic [DATA_W-1:0] mem_wdata;
    logic [7:0]        mem_wmask;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;

    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;

    // slave is the LSU side, master is the core plus data memory
    modport slave (
        input  req_valid, req_op, req_addr, req_wdata,
        input  mem_req_ready, mem_rvalid, mem_rdata, resp_ready,
        output req_ready, mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
        output resp_valid, resp_rdata, resp_err
    );

    modport master (
        output req_valid, req_op, req_addr, req_wdata,
        output mem_req_ready, mem_rvalid, mem_rdata, resp_ready,
        input  req_ready, mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
        input  resp_valid, resp_rdata, resp_err
    );
endinterface
`default_nettype wire

// File: rtl/ysyx_22040931_lsu_ext.sv
`default_nettype none
// ============================================================================
//  Module  : ysyx_22040931_lsu_ext
//  Brief   : Combinational load lane shift and sign/zero extension.
//  Revision: 1.0 - initial release
// ============================================================================
module ysyx_22040931_lsu_ext
    import ysyx_22040931_lsu_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic [DATA_W-1:0] rdata,
    input  logic [2:0]        off,
    input  logic [3:0]        op,
    output logic [DATA_W-1:0] ld_val
);
    logic [DATA_W-1:0] shifted;

    // bytes above the doubleword shift in as zeros
    assign shifted = rdata >> {off, 3'b000};

    always_comb begin
        ld_val = '0;
        case (op)
            c_op_lb:  ld_val = {{(DATA_W-8){shifted[7]}},   shifted[7:0]};
            c_op_lh:  ld_val = {{(DATA_W-16){shifted[15]}}, shifted[15:0]};
            c_op_lw:  ld_val = {{(DATA_W-32){shifted[31]}}, shifted[31:0]};
            c_op_ld:  ld_val = shifted;
            c_op_lbu: ld_val = {{(DATA_W-8){1'b0}},  shifted[7:0]};
            c_op_lhu: ld_val = {{(DATA_W-16){1'b0}}, shifted[15:0]};
            c_op_lwu: ld_val = {{(DATA_W-32){1'b0}}, shifted[31:0]};
            default:  ld_val = '0;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/ysyx_22040931_lsu.sv
`default_nettype none
// ============================================================================
//  Module  : ysyx_22040931_lsu
//  Brief   : Single-outstanding RV64 load/store unit with registered outputs.
//            Define YSYX_22040931_LSU_MISALIGN_CHK_EN to reject misaligned H/W/D.
//  Revision: 1.0 - initial release
// ============================================================================
module ysyx_22040931_lsu
    import ysyx_22040931_lsu_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    ysyx_22040931_lsu_if.slave      bus
);
    logic [1:0]        state_q, state_d;
    logic [3:0]        op_q, op_d;
    logic [2:0]        off_q, off_d;
    logic              mem_req_valid_q, mem_req_valid_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_wen_q, mem_wen_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [7:0]        mem_wmask_q, mem_wmask_d;
    logic              resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
    logic              resp_err_q, resp_err_d;

    logic              accept;
    logic              legal;
    logic              misalign;
    logic [DATA_W-1:0] ld_val;

    assign accept = bus.req_valid && (state_q == c_st_idle);
    assign legal  = op_is_legal(bus.req_op);

`ifdef YSYX_22040931_LSU_MISALIGN_CHK_EN
    assign misalign = legal && is_misaligned(bus.req_op, bus.req_addr[2:0]);
`else
    assign misalign = 1'b0;
`endif

    ysyx_22040931_lsu_ext #(.DATA_W(DATA_W)) u_ext (
        .rdata  (bus.mem_rdata),
        .off    (off_q),
        .op     (op_q),
        .ld_val (ld_val)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= c_st_idle;
            op_q            <= '0;
            off_q           <= '0;
            mem_req_valid_q <= 1'b0;
            mem_addr_q      <= '0;
            mem_wen_q       <= 1'b0;
            mem_wdata_q     <= '0;
            mem_wmask_q     <= '0;
            resp_valid_q    <= 1'b0;
            resp_rdata_q    <= '0;
            resp_err_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            op_q            <= op_d;
            off_q           <= off_d;
            mem_req_valid_q <= mem_req_valid_d;
            mem_addr_q      <= mem_addr_d;
            mem_wen_q       <= mem_wen_d;
            mem_wdata_q     <= mem_wdata_d;
            mem_wmask_q     <= mem_wmask_d;
            resp_valid_q    <= resp_valid_d;
            resp_rdata_q    <= resp_rdata_d;
            resp_err_q      <= resp_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_st_idle: if (accept) state_d = (!legal || misalign) ? c_st_resp : c_st_req;
            c_st_req:  if (bus.mem_req_ready) state_d = op_is_store(op_q) ? c_st_resp : c_st_wait;
            c_st_wait: if (bus.mem_rvalid) state_d = c_st_resp;
            c_st_resp: if (bus.resp_ready) state_d = c_st_idle;
            default:   state_d = c_st_idle;
        endcase
    end

    always_comb begin
        op_d            = op_q;
        off_d           = off_q;
        mem_req_valid_d = mem_req_valid_q;
        mem_addr_d      = mem_addr_q;
        mem_wen_d       = mem_wen_q;
        mem_wdata_d     = mem_wdata_q;
        mem_wmask_d     = mem_wmask_q;
        resp_valid_d    = resp_valid_q;
        resp_rdata_d    = resp_rdata_q;
        resp_err_d      = resp_err_q;
        case (state_q)
            c_st_idle: begin
                if (accept) begin
                    op_d        = bus.req_op;
                    off_d       = bus.req_addr[2:0];
                    mem_addr_d  = {bus.req_addr[ADDR_W-1:3], 3'b000};
                    mem_wen_d   = op_is_store(bus.req_op);
                    mem_wdata_d = bus.req_wdata << {bus.req_addr[2:0], 3'b000};
                    // lanes past byte 7 fall off the 8-bit mask
                    mem_wmask_d = size_mask(bus.req_op) << bus.req_addr[2:0];
                    if (!legal || misalign) begin
                        resp_valid_d = 1'b1;
                        resp_rdata_d = '0;
                        resp_err_d   = misalign;
                    end else begin
                        mem_req_valid_d = 1'b1;
                    end
                end
            end
            c_st_req: begin
                if (bus.mem_req_ready) begin
                    mem_req_valid_d = 1'b0;
                    if (op_is_store(op_q)) begin
                        resp_valid_d = 1'b1;
                        resp_rdata_d = '0;
                        resp_err_d   = 1'b0;
                    end
                end
            end
            c_st_wait: begin
                if (bus.mem_rvalid) begin
                    resp_valid_d = 1'b1;
                    resp_rdata_d = ld_val;
                    resp_err_d   = 1'b0;
                end
            end
            c_st_resp: begin
                if (bus.resp_ready) resp_valid_d = 1'b0;
            end
            default: ;
        endcase
    end

    // req_ready depends on state only so it never combinationally follows an input
    assign bus.req_ready     = (state_q == c_st_idle);
    assign bus.mem_req_valid = mem_req_valid_q;
    assign bus.mem_addr      = mem_addr_q;
    assign bus.mem_wen       = mem_wen_q;
    assign bus.mem_wdata     = mem_wdata_q;
    assign bus.mem_wmask     = mem_wmask_q;
    assign bus.resp_valid    = resp_valid_q;
    assign bus.resp_rdata    = resp_rdata_q;
    assign bus.resp_err      = resp_err_q;

endmodule
`default_nettype wire
